// File: rtl/core_mem_scheduler.sv
// ---------------------------------------------------------------------------
// core_mem_scheduler
//
// Shares the single core-to-memory request channel between the instruction
// cache and the vector load/store unit (LSU). One requester is granted per
// cycle. The icache normally has priority. An LSU request that keeps losing is
// forced through after STARVE_LIMIT denied cycles. Each requester may have at
// most MAX_OUTSTANDING requests in flight. The winning request is registered
// onto mem_req. Registered memory responses are steered back to their owner by
// access_id[6].
//
// Request/response word layout (REQ_W bits, flat vector):
//   [0]       vld        qualifies the word
//   [8:1]     access_id  access_id[6] (bit 7) = 1 -> icache, 0 -> LSU
//   [REQ_W-1:9] payload  opaque; carried through unchanged
//
// Ports:
//   clk               core clock
//   reset             asynchronous, active-low reset
//   icache_mem_req    icache request
//   lsu_mem_req       LSU request
//   mem_stall         memory cannot accept a request this cycle
//   mem_rsp           memory response
//   grant             combinational one-hot grant (bit 0 icache, bit 1 LSU)
//   mem_req           registered request to memory
//   icache_mem_rsp    registered response to icache
//   lsu_mem_rsp       registered response to LSU
//   rsp_underflow     sticky: a response arrived for a requester with none outstanding
//   icache_grant_cnt  icache grant count (statistics)
//   lsu_grant_cnt     LSU grant count (statistics)
//   starve_cnt        count of forced-LSU priority switches (statistics)
//
// Build option:
//   CORE_MEM_SCHED_STATS_EN  when defined, the three statistics counters are
//                            built (saturating at 32'hFFFF_FFFF). When undefined
//                            they read as 0 and no counter flops exist.
// ---------------------------------------------------------------------------
module core_mem_scheduler #(
    parameter int STARVE_LIMIT    = 4,
    parameter int MAX_OUTSTANDING = 64,
    parameter int REQ_W           = 74
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REQ_W-1:0] icache_mem_req,
    input  logic [REQ_W-1:0] lsu_mem_req,
    input  logic             mem_stall,
    input  logic [REQ_W-1:0] mem_rsp,
    output logic [1:0]       grant,
    output logic [REQ_W-1:0] mem_req,
    output logic [REQ_W-1:0] icache_mem_rsp,
    output logic [REQ_W-1:0] lsu_mem_rsp,
    output logic             rsp_underflow,
    output logic [31:0]      icache_grant_cnt,
    output logic [31:0]      lsu_grant_cnt,
    output logic [31:0]      starve_cnt
);

    localparam int VLD_BIT   = 0;
    localparam int OWNER_BIT = 7;  // access_id[6]

    localparam int SW  = $clog2(STARVE_LIMIT + 1);
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [SW-1:0]  STARVE_TRIG = SW'(STARVE_LIMIT - 1);
    localparam logic [SW-1:0]  STARVE_MAX  = SW'(STARVE_LIMIT);
    localparam logic [OCW-1:0] OUT_MAX     = OCW'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        PRIO_IC  = 1'b0,
        PRIO_LSU = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [OCW-1:0]    ic_out_cnt_q, ic_out_cnt_d;
    logic [OCW-1:0]    lsu_out_cnt_q, lsu_out_cnt_d;
    logic              rsp_underflow_q, rsp_underflow_d;
    logic [REQ_W-1:0]  mem_req_q, mem_req_d;
    logic [REQ_W-1:0]  icache_mem_rsp_q, icache_mem_rsp_d;
    logic [REQ_W-1:0]  lsu_mem_rsp_q, lsu_mem_rsp_d;

    logic ic_elig_s;
    logic lsu_elig_s;
    logic lsu_denied_s;
    logic rsp_to_ic_s;
    logic rsp_to_lsu_s;

    // Next value of an outstanding counter, packed as {underflow, count}.
    // Simultaneous increment and decrement cancel out; a decrement at zero
    // holds the count and reports underflow.
    function automatic logic [OCW:0] out_cnt_next(
        input logic [OCW-1:0] cnt,
        input logic           inc,
        input logic           dec
    );
        logic [OCW:0] res;
        if (inc && !dec) begin
            res = {1'b0, cnt + OCW'(1)};
        end else if (!inc && dec) begin
            if (cnt == OCW'(0)) begin
                res = {1'b1, cnt};
            end else begin
                res = {1'b0, cnt - OCW'(1)};
            end
        end else begin
            res = {1'b0, cnt};
        end
        return res;
    endfunction

    // Eligibility: valid, below the in-flight limit, memory not stalled, out of reset.
    always_comb begin
        ic_elig_s  = reset & icache_mem_req[VLD_BIT] & (ic_out_cnt_q < OUT_MAX) & ~mem_stall;
        lsu_elig_s = reset & lsu_mem_req[VLD_BIT] & (lsu_out_cnt_q < OUT_MAX) & ~mem_stall;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PRIO_IC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: hand priority to LSU once it has been denied long enough,
    // and give it back after exactly one LSU grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIO_IC: begin
                if (lsu_denied_s && (starve_q == STARVE_TRIG)) begin
                    state_d = PRIO_LSU;
                end else begin
                    state_d = PRIO_IC;
                end
            end
            PRIO_LSU: begin
                if (grant[1]) begin
                    state_d = PRIO_IC;
                end else begin
                    state_d = PRIO_LSU;
                end
            end
            default: state_d = PRIO_IC;
        endcase
    end

    // FSM output: one-hot grant; state only matters when both are eligible.
    always_comb begin
        grant = 2'b00;
        if (ic_elig_s && lsu_elig_s) begin
            if (state_q == PRIO_LSU) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end else if (ic_elig_s) begin
            grant = 2'b01;
        end else if (lsu_elig_s) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
        lsu_denied_s = lsu_elig_s & ~grant[1];
    end

    // Starvation counter. A stall freezes it so a stalled memory does not
    // erase the LSU's accumulated waiting time.
    always_comb begin
        starve_d = starve_q;
        if (mem_stall) begin
            starve_d = starve_q;
        end else if (lsu_denied_s) begin
            if (starve_q == STARVE_MAX) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end else begin
            starve_d = {SW{1'b0}};
        end
    end

    // Request capture, response steering and outstanding bookkeeping.
    always_comb begin
        rsp_to_ic_s  = mem_rsp[VLD_BIT] & mem_rsp[OWNER_BIT];
        rsp_to_lsu_s = mem_rsp[VLD_BIT] & ~mem_rsp[OWNER_BIT];

        case (grant)
            2'b01:   mem_req_d = icache_mem_req;
            2'b10:   mem_req_d = lsu_mem_req;
            default: mem_req_d = {REQ_W{1'b0}};
        endcase

        if (rsp_to_ic_s) begin
            icache_mem_rsp_d = mem_rsp;
            lsu_mem_rsp_d    = {REQ_W{1'b0}};
        end else if (rsp_to_lsu_s) begin
            icache_mem_rsp_d = {REQ_W{1'b0}};
            lsu_mem_rsp_d    = mem_rsp;
        end else begin
            icache_mem_rsp_d = {REQ_W{1'b0}};
            lsu_mem_rsp_d    = {REQ_W{1'b0}};
        end

        {rsp_underflow_d, ic_out_cnt_d} = out_cnt_next(ic_out_cnt_q, grant[0], rsp_to_ic_s);
        // Sticky: OR in the LSU underflow and the previous flag.
        begin
            logic [OCW:0] lsu_nxt;
            lsu_nxt         = out_cnt_next(lsu_out_cnt_q, grant[1], rsp_to_lsu_s);
            lsu_out_cnt_d   = lsu_nxt[OCW-1:0];
            rsp_underflow_d = rsp_underflow_q | rsp_underflow_d | lsu_nxt[OCW];
        end
    end

    // Datapath and bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q         <= {SW{1'b0}};
            ic_out_cnt_q     <= {OCW{1'b0}};
            lsu_out_cnt_q    <= {OCW{1'b0}};
            rsp_underflow_q  <= 1'b0;
            mem_req_q        <= {REQ_W{1'b0}};
            icache_mem_rsp_q <= {REQ_W{1'b0}};
            lsu_mem_rsp_q    <= {REQ_W{1'b0}};
        end else begin
            starve_q         <= starve_d;
            ic_out_cnt_q     <= ic_out_cnt_d;
            lsu_out_cnt_q    <= lsu_out_cnt_d;
            rsp_underflow_q  <= rsp_underflow_d;
            mem_req_q        <= mem_req_d;
            icache_mem_rsp_q <= icache_mem_rsp_d;
            lsu_mem_rsp_q    <= lsu_mem_rsp_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign icache_mem_rsp = icache_mem_rsp_q;
    assign lsu_mem_rsp    = lsu_mem_rsp_q;
    assign rsp_underflow  = rsp_underflow_q;

`ifdef CORE_MEM_SCHED_STATS_EN
    logic [31:0] ic_gcnt_q, ic_gcnt_d;
    logic [31:0] lsu_gcnt_q, lsu_gcnt_d;
    logic [31:0] sw_cnt_q, sw_cnt_d;
    logic        to_lsu_s;

    // Saturating statistics counters.
    always_comb begin
        to_lsu_s = (state_q == PRIO_IC) && (state_d == PRIO_LSU);
        if (grant[0] && (ic_gcnt_q != 32'hFFFF_FFFF)) begin
            ic_gcnt_d = ic_gcnt_q + 32'd1;
        end else begin
            ic_gcnt_d = ic_gcnt_q;
        end
        if (grant[1] && (lsu_gcnt_q != 32'hFFFF_FFFF)) begin
            lsu_gcnt_d = lsu_gcnt_q + 32'd1;
        end else begin
            lsu_gcnt_d = lsu_gcnt_q;
        end
        if (to_lsu_s && (sw_cnt_q != 32'hFFFF_FFFF)) begin
            sw_cnt_d = sw_cnt_q + 32'd1;
        end else begin
            sw_cnt_d = sw_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ic_gcnt_q  <= 32'd0;
            lsu_gcnt_q <= 32'd0;
            sw_cnt_q   <= 32'd0;
        end else begin
            ic_gcnt_q  <= ic_gcnt_d;
            lsu_gcnt_q <= lsu_gcnt_d;
            sw_cnt_q   <= sw_cnt_d;
        end
    end

    assign icache_grant_cnt = ic_gcnt_q;
    assign lsu_grant_cnt    = lsu_gcnt_q;
    assign starve_cnt       = sw_cnt_q;
`else
    assign icache_grant_cnt = 32'd0;
    assign lsu_grant_cnt    = 32'd0;
    assign starve_cnt       = 32'd0;
`endif

endmodule

// File: tb/tb_core_mem_scheduler.sv
// Testbench for core_mem_scheduler: directed vectors, an abstract per-cycle
// model of the arbitration rules, plus hand-computed literal expectations.
module tb_core_mem_scheduler;

    localparam int REQ_W        = 74;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_OUT      = 64;
`ifdef CORE_MEM_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [REQ_W-1:0] icache_mem_req, lsu_mem_req, mem_rsp;
    logic             mem_stall;
    logic [1:0]       grant;
    logic [REQ_W-1:0] mem_req, icache_mem_rsp, lsu_mem_rsp;
    logic             rsp_underflow;
    logic [31:0]      icache_grant_cnt, lsu_grant_cnt, starve_cnt;

    core_mem_scheduler #(
        .STARVE_LIMIT   (STARVE_LIMIT),
        .MAX_OUTSTANDING(MAX_OUT),
        .REQ_W          (REQ_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .icache_mem_req  (icache_mem_req),
        .lsu_mem_req     (lsu_mem_req),
        .mem_stall       (mem_stall),
        .mem_rsp         (mem_rsp),
        .grant           (grant),
        .mem_req         (mem_req),
        .icache_mem_rsp  (icache_mem_rsp),
        .lsu_mem_rsp     (lsu_mem_rsp),
        .rsp_underflow   (rsp_underflow),
        .icache_grant_cnt(icache_grant_cnt),
        .lsu_grant_cnt   (lsu_grant_cnt),
        .starve_cnt      (starve_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [REQ_W-1:0] mk(input logic v, input logic [7:0] id, input logic [31:0] p);
        return {33'd0, p, id, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- abstract model + per-cycle compare ----------------
    int               m_ic_out, m_lsu_out, m_wait;
    bit               m_owed, m_uf, m_ic_ok, m_lsu_ok;
    longint           m_icg, m_lsug, m_sc;
    logic [1:0]       m_g;
    logic [REQ_W-1:0] m_mem_req, m_ic_rsp, m_lsu_rsp;

    initial begin : model_cmp
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                m_ic_out = 0; m_lsu_out = 0; m_wait = 0; m_owed = 0; m_uf = 0;
                m_icg = 0; m_lsug = 0; m_sc = 0;
                m_mem_req = '0; m_ic_rsp = '0; m_lsu_rsp = '0;
            end
            m_ic_ok  = (reset === 1'b1) && icache_mem_req[0] && (m_ic_out < MAX_OUT) && !mem_stall;
            m_lsu_ok = (reset === 1'b1) && lsu_mem_req[0] && (m_lsu_out < MAX_OUT) && !mem_stall;
            if (m_ic_ok && m_lsu_ok) m_g = m_owed ? 2'b10 : 2'b01;
            else if (m_ic_ok)        m_g = 2'b01;
            else if (m_lsu_ok)       m_g = 2'b10;
            else                     m_g = 2'b00;

            chk("grant", grant, m_g);
            chk("mem_req", mem_req, m_mem_req);
            chk("icache_mem_rsp", icache_mem_rsp, m_ic_rsp);
            chk("lsu_mem_rsp", lsu_mem_rsp, m_lsu_rsp);
            chk("rsp_underflow", rsp_underflow, m_uf);
            chk("icache_grant_cnt", icache_grant_cnt, STATS ? m_icg : 0);
            chk("lsu_grant_cnt", lsu_grant_cnt, STATS ? m_lsug : 0);
            chk("starve_cnt", starve_cnt, STATS ? m_sc : 0);

            if (reset === 1'b1) begin
                m_mem_req = (m_g == 2'b01) ? icache_mem_req : (m_g == 2'b10) ? lsu_mem_req : '0;
                m_ic_rsp  = (mem_rsp[0] && mem_rsp[7])  ? mem_rsp : '0;
                m_lsu_rsp = (mem_rsp[0] && !mem_rsp[7]) ? mem_rsp : '0;
                // LSU waiting time: frozen by stall, reset by relief.
                if (mem_stall) begin
                end else if (m_lsu_ok && m_g != 2'b10) begin
                    m_wait++;
                    if (!m_owed && m_wait >= STARVE_LIMIT) begin
                        m_owed = 1;
                        m_sc++;
                    end
                end else begin
                    m_wait = 0;
                end
                if (m_g == 2'b10) m_owed = 0;
                // in-flight accounting
                m_ic_out  += (m_g == 2'b01) ? 1 : 0;
                m_lsu_out += (m_g == 2'b10) ? 1 : 0;
                if (mem_rsp[0] && mem_rsp[7])  begin if (m_ic_out == 0)  m_uf = 1; else m_ic_out--;  end
                if (mem_rsp[0] && !mem_rsp[7]) begin if (m_lsu_out == 0) m_uf = 1; else m_lsu_out--; end
                if (m_g == 2'b01) m_icg++;
                if (m_g == 2'b10) m_lsug++;
            end
        end
    end

    // ---------------- directed stimulus + literal pins ----------------
    logic [1:0]       pat [7];
    logic [REQ_W-1:0] r, rsp;

    initial begin
        reset = 1'b0; icache_mem_req = '0; lsu_mem_req = '0; mem_stall = 1'b0; mem_rsp = '0;
        tick();
        // grant stays 0 while reset is asserted
        icache_mem_req = mk(1'b1, 8'h40, 32'hDEAD_0001);
        @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_underflow", rsp_underflow, 1'b0);
        tick();
        icache_mem_req = '0; reset = 1'b1;
        tick();

        // icache alone for 3 cycles
        for (int i = 0; i < 3; i++) begin
            r = mk(1'b1, 8'h40, 32'h1000_0000 + i);
            icache_mem_req = r;
            @(negedge clk);
            chk("t1_grant", grant, 2'b01);
            tick();
            chk("t1_mem_req", mem_req, r);
        end
        icache_mem_req = '0;
        chk("t1_ic_out_cnt", dut.ic_out_cnt_q, 3);

        // both valid: 01 01 01 01 10 repeating
        icache_mem_req = mk(1'b1, 8'h40, 32'h2000_0000);
        lsu_mem_req    = mk(1'b1, 8'h00, 32'h3000_0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_grant", grant, (i % 5 == 4) ? 2'b10 : 2'b01);
            tick();
            if (i == 4) chk("t2_starve_cnt5", starve_cnt, STATS ? 1 : 0);
        end
        chk("t2_ic_gcnt", icache_grant_cnt, STATS ? 11 : 0);
        chk("t2_lsu_gcnt", lsu_grant_cnt, STATS ? 2 : 0);

        // stall for 2 cycles mid-wait: starvation count frozen, then LSU forced
        pat[0] = 2'b01; pat[1] = 2'b01; pat[2] = 2'b00; pat[3] = 2'b00;
        pat[4] = 2'b01; pat[5] = 2'b01; pat[6] = 2'b10;
        for (int i = 0; i < 7; i++) begin
            mem_stall = (i == 2 || i == 3);
            @(negedge clk);
            chk("t5_grant", grant, pat[i]);
            tick();
            if (i == 2 || i == 3) chk("t5_mem_req_zero", mem_req, 0);
        end
        mem_stall = 1'b0;
        icache_mem_req = '0;

        // LSU fills to 64 outstanding, then one response frees a slot
        for (int i = 0; i < 64; i++) tick();
        @(negedge clk);
        chk("t3_full_grant", grant, 2'b00);
        chk("t3_lsu_out_cnt", dut.lsu_out_cnt_q, 64);
        rsp = mk(1'b1, 8'h00, 32'h0000_4444);
        tick();
        mem_rsp = rsp;
        @(negedge clk);
        chk("t3_still_full", grant, 2'b00);
        tick();
        mem_rsp = '0;
        @(negedge clk);
        chk("t3_lsu_rsp", lsu_mem_rsp, rsp);
        chk("t3_ic_rsp_zero", icache_mem_rsp, 0);
        chk("t3_regrant", grant, 2'b10);
        tick();
        lsu_mem_req = '0;

        // icache grant and icache response in the same cycle
        chk("t4_ic_out_before", dut.ic_out_cnt_q, 15);
        r   = mk(1'b1, 8'h40, 32'h0000_5555);
        rsp = mk(1'b1, 8'h40, 32'h0000_6666);
        icache_mem_req = r; mem_rsp = rsp;
        @(negedge clk);
        chk("t4_grant", grant, 2'b01);
        tick();
        icache_mem_req = '0; mem_rsp = '0;
        @(negedge clk);
        chk("t4_ic_rsp", icache_mem_rsp, rsp);
        chk("t4_lsu_rsp_zero", lsu_mem_rsp, 0);
        chk("t4_mem_req", mem_req, r);
        chk("t4_ic_out_after", dut.ic_out_cnt_q, 15);

        // reset mid-burst, in-flight LSU response after reset -> underflow
        icache_mem_req = mk(1'b1, 8'h40, 32'h7000_0000);
        lsu_mem_req    = mk(1'b1, 8'h01, 32'h8000_0000);
        rsp = mk(1'b1, 8'h01, 32'h0000_7777);
        mem_rsp = rsp;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_grant", grant, 2'b00);
        chk("t6_rst_mem_req", mem_req, 0);
        chk("t6_rst_lsu_out", dut.lsu_out_cnt_q, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_burst_grant", grant, 2'b01);
            if (i > 0) chk("t6_underflow", rsp_underflow, 1'b1);
            if (i == 1) chk("t6_lsu_rsp", lsu_mem_rsp, rsp);
            tick();
            mem_rsp = '0;
        end
        // FSM now owes LSU a grant; reset must drop that
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst2_underflow", rsp_underflow, 1'b0);
        chk("t6_rst2_mem_req", mem_req, 0);
        chk("t6_rst2_lsu_rsp", lsu_mem_rsp, 0);
        chk("t6_rst2_starve_cnt", starve_cnt, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_prio_ic_after_reset", grant, 2'b01);
        tick();
        icache_mem_req = '0; lsu_mem_req = '0;
        tick();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
